// File: rtl/counter_access_ctrl.sv
// Round-robin arbiter that lends one shared up/down counter to two requesters,
// stepping it one enable pulse at a time toward each requester's target.
module counter_access_ctrl #(
  parameter int WIDTH         = 4,
  parameter int TIMEOUT_STEPS = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] tgt0,
  input  logic [WIDTH-1:0] tgt1,
  output logic [1:0]       gnt,
  output logic [1:0]       ack,
  output logic             err,
  output logic             busy,
  input  logic [WIDTH-1:0] cnt_value,
  output logic             cnt_enable,
  output logic             cnt_up_down
);

  localparam int SW = $clog2(TIMEOUT_STEPS + 1);

  typedef enum logic [1:0] {IDLE, CMP, STEP, DONE} state_t;

  state_t           state_q, state_d;
  logic [1:0]       gnt_q, gnt_d;
  logic [1:0]       ack_q, ack_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;
  logic             en_q, en_d;
  logic             ud_q, ud_d;
  logic             last_gnt_q, last_gnt_d;
  logic [WIDTH-1:0] tgt_q, tgt_d;
  logic [SW-1:0]    steps_q, steps_d;
  logic             pick;

  // On contention the requester that was not served last wins.
  assign pick = (req == 2'b11) ? ~last_gnt_q : req[1];

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    ack_d      = '0;
    err_d      = err_q;
    busy_d     = busy_q;
    en_d       = en_q;
    ud_d       = ud_q;
    last_gnt_d = last_gnt_q;
    tgt_d      = tgt_q;
    steps_d    = steps_q;
    case (state_q)
      IDLE: begin
        if (req != 2'b00) begin
          gnt_d      = pick ? 2'b10 : 2'b01;
          last_gnt_d = pick;
          tgt_d      = pick ? tgt1 : tgt0;
          steps_d    = '0;
          err_d      = 1'b0;
          busy_d     = 1'b1;
          state_d    = CMP;
        end
      end
      CMP: begin
        if (cnt_value == tgt_q) begin
          ack_d   = gnt_q;
          err_d   = 1'b0;
          state_d = DONE;
        end else if (steps_q == SW'(TIMEOUT_STEPS)) begin
          ack_d   = gnt_q;
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          ud_d    = (tgt_q > cnt_value);
          en_d    = 1'b1;
          steps_d = steps_q + SW'(1);
          state_d = STEP;
        end
      end
      STEP: begin
        // The counter moves on the edge closing this cycle; CMP then sees it.
        en_d    = 1'b0;
        state_d = CMP;
      end
      DONE: begin
        gnt_d   = '0;
        err_d   = 1'b0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      ack_q      <= '0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      en_q       <= 1'b0;
      ud_q       <= 1'b1;
      last_gnt_q <= 1'b1;
      tgt_q      <= '0;
      steps_q    <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      en_q       <= en_d;
      ud_q       <= ud_d;
      last_gnt_q <= last_gnt_d;
      tgt_q      <= tgt_d;
      steps_q    <= steps_d;
    end
  end

  assign gnt         = gnt_q;
  assign ack         = ack_q;
  assign err         = err_q;
  assign busy        = busy_q;
  assign cnt_enable  = en_q;
  assign cnt_up_down = ud_q;

endmodule

// File: tb/tb_counter_access_ctrl.sv
// Bench for counter_access_ctrl: a behavioural counter plus a transaction-level
// model predicting owner, pulse count, direction, latency, error and final count.
module tb_counter_access_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] req;
  logic [3:0] tgt0, tgt1;
  logic [1:0] gnt, ack;
  logic       err, busy;
  logic [3:0] cnt;
  logic       cnt_enable, cnt_up_down;

  logic       cnt_load = 1'b0;
  logic [3:0] cnt_load_val = 4'd0;
  bit         interfere = 1'b0;
  logic       last_gnt;
  int         n_checks = 0;
  int         n_fail = 0;

  counter_access_ctrl #(.WIDTH(4), .TIMEOUT_STEPS(16)) dut (
    .clk(clk), .reset(reset), .req(req), .tgt0(tgt0), .tgt1(tgt1),
    .gnt(gnt), .ack(ack), .err(err), .busy(busy),
    .cnt_value(cnt), .cnt_enable(cnt_enable), .cnt_up_down(cnt_up_down)
  );

  always #5 clk = ~clk;

  // The shared counter; when interfering, an outside source zeroes it on every step.
  always @(posedge clk) begin
    if (cnt_load) cnt <= cnt_load_val;
    else if (cnt_enable) begin
      if (interfere)        cnt <= 4'd0;
      else if (cnt_up_down) cnt <= cnt + 4'd1;
      else if (cnt != 4'd0) cnt <= cnt - 4'd1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_count(input logic [3:0] v);
    cnt_load_val = v;
    cnt_load = 1'b1;
    @(negedge clk);
    cnt_load = 1'b0;
  endtask

  // Called at a negedge inside an IDLE cycle (cycle 0) with req already driven.
  task automatic serve();
    logic       o;
    logic [3:0] t, start, exp_cnt;
    int         exp_p, p, c, ack_c;
    bit         done, prev_en, exp_err;
    o       = (req == 2'b11) ? ~last_gnt : req[1];
    t       = o ? tgt1 : tgt0;
    start   = cnt;
    exp_err = interfere && (start != t);
    exp_p   = exp_err ? 16 : ((t > start) ? int'(t - start) : int'(start - t));
    exp_cnt = exp_err ? 4'd0 : t;
    check_eq("idle_busy", {31'd0, busy}, 32'd0);
    done = 0; prev_en = 0; p = 0; ack_c = 0;
    for (c = 1; c <= 60 && !done; c++) begin
      @(negedge clk);
      if (c == 1) begin
        check_eq("gnt", {30'd0, gnt}, o ? 32'd2 : 32'd1);
        check_eq("busy", {31'd0, busy}, 32'd1);
      end
      if (cnt_enable) begin
        p++;
        check_eq("dir", {31'd0, cnt_up_down}, {31'd0, (t > cnt)});
        check_eq("spacing", {31'd0, prev_en}, 32'd0);
      end
      prev_en = cnt_enable;
      if (ack != 2'b00) begin
        done  = 1;
        ack_c = c;
        check_eq("ack", {30'd0, ack}, o ? 32'd2 : 32'd1);
        check_eq("err", {31'd0, err}, {31'd0, exp_err});
        check_eq("latency", ack_c, 2 + 2 * exp_p);
        check_eq("pulses", p, exp_p);
        check_eq("count", {28'd0, cnt}, {28'd0, exp_cnt});
      end
    end
    if (!done) check_eq("ack_seen", 32'd0, 32'd1);
    $display("txn owner=%0d start=%0d tgt=%0d pulses=%0d ack_cycle=%0d err=%0b",
             o, start, t, p, ack_c, err);
    last_gnt = o;
    req[o]   = 1'b0;
    @(negedge clk);
  endtask

  task automatic serve_all();
    while (req != 2'b00) serve();
  endtask

  initial begin
    int wait_c;
    reset = 1'b1; req = 2'b00; tgt0 = 4'd0; tgt1 = 4'd0; last_gnt = 1'b1;
    cnt_load_val = 4'd0; cnt_load = 1'b1;
    repeat (2) @(negedge clk);
    cnt_load = 1'b0;
    check_eq("rst_gnt", {30'd0, gnt}, 32'd0);
    check_eq("rst_ack", {30'd0, ack}, 32'd0);
    check_eq("rst_err", {31'd0, err}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_en", {31'd0, cnt_enable}, 32'd0);
    check_eq("rst_ud", {31'd0, cnt_up_down}, 32'd1);
    reset = 1'b0;
    @(negedge clk);

    // Both request after reset, then the directed single moves, then both again.
    set_count(4'd0); tgt0 = 4'd1; tgt1 = 4'd4; req = 2'b11; serve_all();
    set_count(4'd3); tgt0 = 4'd7; req = 2'b01; serve_all();
    set_count(4'd9); tgt1 = 4'd2; req = 2'b10; serve_all();
    set_count(4'd5); tgt0 = 4'd5; req = 2'b01; serve_all();
    set_count(4'd2); tgt0 = 4'd0; tgt1 = 4'd15; req = 2'b11; serve_all();

    // External interference keeps zeroing the counter: timeout with err.
    interfere = 1'b1;
    set_count(4'd0); tgt0 = 4'd3; req = 2'b01; serve_all();
    interfere = 1'b0;

    // Reset in the middle of a move.
    set_count(4'd0); tgt0 = 4'd10; req = 2'b01;
    wait_c = 0;
    while (!cnt_enable && wait_c < 10) begin
      @(negedge clk);
      wait_c++;
    end
    check_eq("reached_step", {31'd0, cnt_enable}, 32'd1);
    reset = 1'b1;
    #1;
    check_eq("mid_rst_en", {31'd0, cnt_enable}, 32'd0);
    check_eq("mid_rst_gnt", {30'd0, gnt}, 32'd0);
    check_eq("mid_rst_busy", {31'd0, busy}, 32'd0);
    req = 2'b00;
    repeat (2) begin
      @(negedge clk);
      check_eq("mid_rst_noack", {30'd0, ack}, 32'd0);
    end
    reset = 1'b0;
    last_gnt = 1'b1;
    @(negedge clk);
    check_eq("post_rst_noack", {30'd0, ack}, 32'd0);
    tgt1 = 4'd6; req = 2'b10; serve_all();

    // Randomized transactions.
    for (int i = 0; i < 25; i++) begin
      interfere = ($urandom_range(0, 5) == 0);
      tgt0 = 4'($urandom_range(0, 15));
      tgt1 = 4'($urandom_range(0, 15));
      if (interfere && tgt0 == 4'd0) tgt0 = 4'd9;
      if (interfere && tgt1 == 4'd0) tgt1 = 4'd5;
      set_count(4'($urandom_range(0, 15)));
      req = 2'($urandom_range(1, 3));
      serve_all();
    end
    interfere = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
